// File: rtl/a_ctrls_pkg.sv
// a_ctrls_pkg: constants and helpers shared by the control-value UART
// transmitter (a_ctrls_tx) and its matching receiver/decoder.
//   N_CTRL     number of control channels carried by the link
//   CH_BASE    ASCII code of the first channel letter ('A')
//   EOP        end-of-packet byte (line feed)
//   hex_ascii  4-bit nibble -> uppercase ASCII hex digit
//   ctrl_state_t  packet sequencer states
package a_ctrls_pkg;

    localparam int         N_CTRL  = 7;
    localparam logic [7:0] CH_BASE = 8'h41;
    localparam logic [7:0] EOP     = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } ctrl_state_t;

    // '0'..'9' -> 0x30..0x39, 'A'..'F' -> 0x41..0x46 (0x37 + 10 = 0x41)
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 byte serializer with its own bit-period divider.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_tx_data        byte to send, sampled when i_new_tx_data is accepted
//   i_new_tx_data    request; accepted on a rising edge where o_tx_busy is low
//   o_ser_out        serial line, idle high
//   o_tx_busy        high while a frame is being shifted out
//   o_tx_done        high during the final clk cycle of the stop bit
// Handshake: i_new_tx_data acts as valid and !o_tx_busy as ready; a byte is
// transferred on any rising edge where both are high, and the requester must
// hold i_tx_data stable while valid is asserted.
module uart_tx #(
    parameter int DIV = 5208
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_new_tx_data,
    output logic       o_ser_out,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx: DIV must be at least 2");
    end

    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

    // r_frame holds {stop, data[7:0], start}; bit 0 drives the line, and the
    // frame shifts right with 1s filling in, so it reads all-ones when idle.
    logic [9:0]    r_frame;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic          r_busy;
    logic          w_last;

    assign w_last = r_busy && (r_bit == 4'd9) && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame <= '1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
        end else if (!r_busy) begin
            if (i_new_tx_data) begin
                r_frame <= {1'b1, i_tx_data, 1'b0};
                r_cnt   <= '0;
                r_bit   <= '0;
                r_busy  <= 1'b1;
            end
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_frame <= {1'b1, r_frame[9:1]};
            if (r_bit == 4'd9) r_busy <= 1'b0;
            else               r_bit  <= r_bit + 4'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_ser_out = r_frame[0];
    assign o_tx_busy = r_busy;
    assign o_tx_done = w_last;

endmodule

// File: rtl/a_ctrls_tx.sv
// a_ctrls_tx: watches N_CTRL 8-bit control values and sends a 4-byte ASCII
// packet {'A'+ch, hex hi, hex lo, LF} over an 8N1 UART whenever a value
// changes, or for every channel after a refresh strobe.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   in[0:6]       control values, synchronous to clk
//   refresh       one-cycle strobe marking every channel pending
//   CTRL_TX       serial output, idle high
//   busy          high from the cycle after a channel is selected until the
//                 sequencer is back in IDLE
module a_ctrls_tx
    import a_ctrls_pkg::*;
#(
    parameter int fCLK  = 50_000_000,
    parameter int fBAUD = 9_600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in [0:N_CTRL-1],
    input  logic       refresh,
    output logic       CTRL_TX,
    output logic       busy
);

    localparam int DIV = fCLK / fBAUD;

    ctrl_state_t        r_state;
    logic [N_CTRL-1:0]  r_pending;
    logic [7:0]         r_shadow [0:N_CTRL-1];
    logic [2:0]         r_rr;
    logic [2:0]         r_ch;
    logic [7:0]         r_val;
    logic [1:0]         r_k;

    logic               w_found;
    logic [2:0]         w_sel;
    logic [3:0]         w_sum;
    logic               w_fire;
    logic               w_is_sel;
    logic [N_CTRL-1:0]  w_pend_nxt;
    logic [7:0]         w_tx_byte;
    logic               w_new;
    logic               w_tx_busy;
    logic               w_tx_done;
    logic               w_ser;

    // Round-robin pick: first pending channel at or after r_rr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            w_sum = {1'b0, r_rr} + 4'(k);
            if (w_sum >= 4'(N_CTRL)) w_sum = w_sum - 4'(N_CTRL);
            if (!w_found && r_pending[w_sum[2:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[2:0];
            end
        end
    end

    assign w_fire = (r_state == ST_IDLE) && w_found;

    // The channel being selected copies in[] into its shadow this very cycle,
    // so its stale shadow must not count as a difference; any other set
    // source (refresh) still wins over the selection clear.
    always_comb begin
        w_pend_nxt = r_pending;
        w_is_sel   = 1'b0;
        for (int i = 0; i < N_CTRL; i++) begin
            w_is_sel = w_fire && (w_sel == 3'(i));
            if (w_is_sel) w_pend_nxt[i] = 1'b0;
            if (refresh || ((in[i] != r_shadow[i]) && !w_is_sel))
                w_pend_nxt[i] = 1'b1;
        end
    end

    always_comb begin
        case (r_k)
            2'd0:    w_tx_byte = CH_BASE + {5'b0, r_ch};
            2'd1:    w_tx_byte = hex_ascii(r_val[7:4]);
            2'd2:    w_tx_byte = hex_ascii(r_val[3:0]);
            default: w_tx_byte = EOP;
        endcase
    end

    // LOAD presents the byte; it is handed over as soon as the serializer is
    // free, which keeps consecutive frames within one idle cycle of each other.
    assign w_new = (r_state == ST_LOAD) && !w_tx_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_rr      <= '0;
            r_ch      <= '0;
            r_val     <= '0;
            r_k       <= '0;
            for (int i = 0; i < N_CTRL; i++) r_shadow[i] <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_ch            <= w_sel;
                        r_val           <= in[w_sel];
                        r_shadow[w_sel] <= in[w_sel];
                        r_rr            <= (w_sel == 3'(N_CTRL - 1)) ? 3'd0 : w_sel + 3'd1;
                        r_k             <= 2'd0;
                        r_state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!w_tx_busy) r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_tx_done) begin
                        if (r_k == 2'd3) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_k     <= r_k + 2'd1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    uart_tx #(
        .DIV(DIV)
    ) u_uart_tx (
        .i_clk         (clk),
        .i_rst_n       (reset_n),
        .i_tx_data     (w_tx_byte),
        .i_new_tx_data (w_new),
        .o_ser_out     (w_ser),
        .o_tx_busy     (w_tx_busy),
        .o_tx_done     (w_tx_done)
    );

    assign CTRL_TX = w_ser;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_a_ctrls_tx.sv
module tb_a_ctrls_tx;

    localparam int FCLK  = 50_000_000;
    localparam int FBAUD = 5_000_000;
    localparam int DIV   = FCLK / FBAUD;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_v [0:6];
    logic       refresh;
    logic       ctrl_tx;
    logic       busy;

    a_ctrls_tx #(.fCLK(FCLK), .fBAUD(FBAUD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (in_v),
        .refresh (refresh),
        .CTRL_TX (ctrl_tx),
        .busy    (busy)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int busy_cnt = 0;
    always @(negedge clk) if (busy === 1'b1) busy_cnt <= busy_cnt + 1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_t_q[$];
    int         first_start;

    // behavioural model: the value last presented per channel, next-turn channel
    logic [7:0] mdl_val [0:6];
    int         mdl_rr;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // ---------------- line monitor (UART decoder) ----------------
    logic       mon_active = 1'b0;
    int         mon_frames = 0;
    logic [9:0] mon_bits;
    logic       mon_ok;
    logic       mon_abort;
    int         mon_t0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && ctrl_tx === 1'b0) begin
                mon_active = 1'b1;
                mon_t0     = cyc;
                mon_frames++;
                mon_ok     = 1'b1;
                mon_abort  = 1'b0;
                mon_bits   = '0;
                for (int b = 0; b < 10 && !mon_abort; b++) begin
                    for (int s = 0; s < DIV; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (reset_n !== 1'b1) begin
                            mon_abort = 1'b1;
                            break;
                        end
                        if (s == 0) mon_bits[b] = ctrl_tx;
                        else if (ctrl_tx !== mon_bits[b]) mon_ok = 1'b0;
                    end
                end
                if (!mon_abort) begin
                    n_checks++;
                    if (!mon_ok || mon_bits[9] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL frame_shape: got bits %b (steady=%0d) expected start 0, 8 data, stop 1, each %0d cycles",
                                 mon_bits, mon_ok, DIV);
                    end
                    rx_q.push_back(mon_bits[8:1]);
                    rx_t_q.push_back(mon_t0);
                end
                mon_active = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        int d;
        d = int'(n);
        if (d < 10) return 8'(48 + d);
        return 8'(65 + d - 10);
    endfunction

    function automatic void mdl_push_pkt(input int ch, input logic [7:0] v);
        exp_q.push_back(8'(65 + ch));
        exp_q.push_back(hex_char(v[7:4]));
        exp_q.push_back(hex_char(v[3:0]));
        exp_q.push_back(8'd10);
    endfunction

    // Channels flagged in mask all became pending together while idle: they
    // go out in turn starting at mdl_rr, each with its current value.
    function automatic void mdl_send(input logic [6:0] mask);
        int last;
        last = -1;
        for (int k = 0; k < 7; k++) begin
            int ch;
            ch = (mdl_rr + k) % 7;
            if (mask[ch]) begin
                mdl_push_pkt(ch, mdl_val[ch]);
                last = ch;
            end
        end
        if (last >= 0) mdl_rr = (last + 1) % 7;
    endfunction

    // ---------------- driver / scoreboard tasks ----------------
    task automatic flush(input string name, input int budget);
        int n;
        int nexp;
        n    = 0;
        nexp = exp_q.size();
        while (n < budget && !(rx_q.size() >= nexp && busy === 1'b0 && mon_active == 1'b0)) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes expected %0d within %0d cycles", name, rx_q.size(), nexp, budget);
        end
        repeat (3 * DIV) @(negedge clk);
        check({name, "_count"}, rx_q.size(), nexp);
        first_start = (rx_t_q.size() > 0) ? rx_t_q[0] : -1000;
        for (int j = 0; j < nexp && j < rx_q.size(); j++)
            check({name, "_byte"}, {24'h0, rx_q[j]}, {24'h0, exp_q[j]});
        for (int j = 1; j < rx_t_q.size(); j++)
            if (j % 4 != 0)
                check_range({name, "_gap"}, rx_t_q[j] - rx_t_q[j-1], 10 * DIV, 10 * DIV + 1);
        exp_q.delete();
        rx_q.delete();
        rx_t_q.delete();
    endtask

    task automatic idle_watch(input string name, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ctrl_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check({name, "_active_cycles"}, bad, 0);
        check({name, "_rx_bytes"}, rx_q.size(), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          ch;
        logic [7:0]  val;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int t_apply;
        int n;
        int base;
        logic [6:0] mask;
        logic       do_ref;
        logic [7:0] v;

        vecs[0] = '{ch: 2, val: 8'h5C, exp: 32'h4335_430A};
        vecs[1] = '{ch: 5, val: 8'hA7, exp: 32'h4641_370A};
        vecs[2] = '{ch: 1, val: 8'h09, exp: 32'h4230_390A};
        vecs[3] = '{ch: 4, val: 8'hF0, exp: 32'h4546_300A};
        vecs[4] = '{ch: 6, val: 8'h3E, exp: 32'h4733_450A};

        reset_n = 1'b0;
        refresh = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_v[i]    = 8'h00;
            mdl_val[i] = 8'h00;
        end
        mdl_rr = 0;

        // reset state
        repeat (5) @(negedge clk);
        check("reset_ctrl_tx", {31'h0, ctrl_tx}, 32'h1);
        check("reset_busy", {31'h0, busy}, 32'h0);
        reset_n = 1'b1;

        // quiet inputs: nothing on the line
        idle_watch("idle_after_reset", 1000);

        // single-channel changes from the table
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            busy_cnt = 0;
            t_apply  = cyc;
            in_v[vecs[i].ch]    = vecs[i].val;
            mdl_val[vecs[i].ch] = vecs[i].val;
            mdl_rr = (vecs[i].ch + 1) % 7;
            for (int b = 3; b >= 0; b--) exp_q.push_back(vecs[i].exp[8*b +: 8]);
            flush("vec", 1000);
            check_range("vec_latency", first_start - t_apply, 1, 4);
            check_range("vec_busy_cycles", busy_cnt, 40 * DIV, 40 * DIV + 4);
        end

        // two channels change together: ch0 goes before ch6
        @(negedge clk);
        in_v[0] = 8'h01;
        in_v[6] = 8'hFF;
        mdl_val[0] = 8'h01;
        mdl_val[6] = 8'hFF;
        mdl_rr = 0;
        exp_q = '{8'h41, 8'h30, 8'h31, 8'h0A, 8'h47, 8'h46, 8'h46, 8'h0A};
        flush("pair", 1500);

        // value changes twice while its own packet is on the line
        @(negedge clk);
        in_v[3] = 8'h10;
        repeat (50) @(negedge clk);
        check("step_busy", {31'h0, busy}, 32'h1);
        in_v[3] = 8'h11;
        repeat (100) @(negedge clk);
        in_v[3] = 8'h12;
        mdl_val[3] = 8'h12;
        mdl_rr = 4;
        exp_q = '{8'h44, 8'h31, 8'h30, 8'h0A, 8'h44, 8'h31, 8'h32, 8'h0A};
        flush("step", 1500);

        // preset in = {0..6}, ending on channel 6 so the turn pointer wraps to 0
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            in_v[i]    = 8'(i);
            mdl_val[i] = 8'(i);
        end
        mdl_send(7'h3F);
        flush("preset", 4000);
        @(negedge clk);
        in_v[6]    = 8'd6;
        mdl_val[6] = 8'd6;
        mdl_send(7'h40);
        flush("preset6", 1000);

        // refresh with nothing changed: all seven channels A..G
        @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        mdl_send(7'h7F);
        flush("refresh", 4000);

        // random channel sets, sometimes with a refresh in the same cycle
        for (int r = 0; r < 10; r++) begin
            mask   = 7'($urandom_range(1, 127));
            do_ref = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            for (int i = 0; i < 7; i++) begin
                if (mask[i]) begin
                    v = 8'($urandom_range(0, 255));
                    if (v == mdl_val[i]) v = v ^ 8'h01;
                    in_v[i]    = v;
                    mdl_val[i] = v;
                end
            end
            refresh = do_ref;
            @(negedge clk);
            refresh = 1'b0;
            mdl_send(do_ref ? 7'h7F : mask);
            flush("rand", 4000);
        end

        // reset while bit 5 (a 0) of byte1 is on the line
        @(negedge clk);
        v = (mdl_val[1] == 8'hB2) ? 8'hB3 : 8'hB2;
        in_v[1] = v;
        base = mon_frames;
        n = 0;
        while (mon_frames < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_range("rst_byte1_wait", n, 0, 499);
        repeat (5 * DIV + 2) @(negedge clk);
        check("rst_line_low_before", {31'h0, ctrl_tx}, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_ctrl_tx_immediate", {31'h0, ctrl_tx}, 32'h1);
        check("rst_busy_immediate", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 7; i++) begin
            in_v[i]    = 8'h00;
            mdl_val[i] = 8'h00;
        end
        mdl_rr = 0;
        repeat (5) @(negedge clk);
        exp_q.delete();
        rx_q.delete();
        rx_t_q.delete();
        reset_n = 1'b1;
        idle_watch("idle_after_midframe_reset", 1000);

        // recovers with a fresh change
        @(negedge clk);
        in_v[2] = 8'h5C;
        exp_q = '{8'h43, 8'h35, 8'h43, 8'h0A};
        flush("recover", 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout at cycle %0d expected end of test", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/a_ctrls_tx.md
Name: a_ctrls_tx

Overview:
Transmit-side counterpart of the control-value UART link. Watches seven 8-bit control values and sends a 4-byte ASCII packet over a UART line whenever a value changes, or for every channel on request. Runs 8N1 at fBAUD with its own bit-rate divider. Intended for the control-panel FPGA or the loopback bench driving CTRL_RX of the theremin.

Parameters:
fCLK, 50_000_000, system clock frequency in Hz
fBAUD, 9_600, line rate in baud; bit period DIV = fCLK/fBAUD, integer division (5208 at defaults)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
in  input  8 x [0:6]  control values, synchronous to clk, unpacked array
refresh  input  1  one-cycle strobe: mark all seven channels pending
CTRL_TX  output  1  UART serial out, idle high
busy  output  1  high while a packet is being serialized

Behaviour:
- Reset state: CTRL_TX=1, busy=0, shadow[0..6]=0, pending=0, rr pointer=0, FSM IDLE.
- Packet for channel i with value v: byte0 = 'A'+i (0x41..0x47), byte1 = ASCII hex of v[7:4], byte2 = ASCII hex of v[3:0], byte3 = 0x0A. Hex digits are uppercase: '0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46.
- Change detect, every cycle: pending[i] is set when in[i] != shadow[i]. refresh sets all pending bits. A set has priority over a clear in the same cycle.
- Arbitration: in IDLE with any pending bit set, pick the first pending index at or after rr, wrapping 6 to 0.
  - Selection cycle: latch v = in[i], write shadow[i] = v, clear pending[i], set rr = i+1 (mod 7).
  - If in[i] changes again while busy, it differs from shadow and is re-sent later. Intermediate values may be dropped; the last value always gets sent.
- FSM: IDLE -> LOAD -> SEND (byte k = 0..3) -> IDLE.
  - LOAD: one cycle, forms the byte.
  - SEND: waits for serializer done, then k++. After byte3 returns to IDLE.
  - busy = 1 from the cycle after selection until the cycle IDLE is re-entered.
- Serializer frame: start bit 0, data bits LSB first, stop bit 1. Each bit held exactly DIV clk cycles.
  - Consecutive bytes are back-to-back: the next start bit follows the stop bit, with at most 1 extra idle cycle.
- Latency: from a change on in[i] with the FSM idle, the CTRL_TX start-bit falling edge comes within 4 clk cycles.
- Packet duration is 40 bit periods; 40*DIV (+ at most 4 cycles) clk cycles.
- Reset mid-frame: asynchronous return to reset state; CTRL_TX goes high immediately. Nothing is resumed.
- Bit counter width: $clog2(DIV); DIV < 2 is illegal and checked by an elaboration-time assertion.

Decomposition:
- Package a_ctrls_pkg holds:
  - N_CTRL = 7
  - CH_BASE = 8'h41
  - EOP = 8'h0A
  - function hex_ascii(4-bit) -> 8-bit
  - typedef enum of FSM states
- The matching decoder imports the same package.
- One sub-module, uart_tx:
  - Inputs clock, reset, tx_data[7:0], new_tx_data.
  - Outputs ser_out, tx_busy, tx_done (one-cycle pulse at the end of the stop bit).
  - Contains the DIV counter.

Test Plan (fCLK=50_000_000, fBAUD=5_000_000, DIV=10):
- Reset, then hold in=0 -> CTRL_TX stays 1, busy stays 0 for 1000 cycles.
- in[2]: 0 -> 0x5C -> line carries 0x43,0x35,0x43,0x0A; each bit 10 cycles; busy high ~400 cycles; then idle.
- in[0]=0x01 and in[6]=0xFF in the same cycle -> channel 0 packet 'A','0','1',LF, then 'G','F','F',LF; then idle.
- in[3] steps 0x10 -> 0x11 -> 0x12 during the packet for 0x10 -> second packet carries 0x12 only (0x11 dropped).
- refresh pulse with in={0..6}={0,1,2,3,4,5,6} and no changes -> seven packets 'A'..'G' in order, values "00".."06", rr wrap verified.
- Assert reset_n low at the 5th bit of byte1 -> CTRL_TX=1 the same cycle; after release no transmission until a new change or refresh.
